// File: rtl/game_pkg.sv
// Shared constants and types for the falling-sprite game.
// Screen geometry, palette and sprite-engine states.
package game_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   localparam logic [2:0] BG_COLOUR       = 3'b000;
   localparam logic [2:0] OBSTACLE_COLOUR = 3'b010;
   localparam logic [2:0] PLAYER_COLOUR   = 3'b110;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ERASE,
      S_UPDATE,
      S_PROBE,
      S_DRAW,
      S_DONE
   } sprite_state_t;

endpackage

// File: rtl/player_sprite_engine_if.sv
// VGA plot port and framebuffer read port of the sprite engine.
// master = sprite engine, slave = VGA adapter / framebuffer.
interface player_sprite_engine_if;

   logic [7:0] rd_x;
   logic [6:0] rd_y;
   logic [2:0] rd_colour;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot;

   modport master (
      output rd_x, rd_y, x, y, colour, plot,
      input  rd_colour
   );

   modport slave (
      input  rd_x, rd_y, x, y, colour, plot,
      output rd_colour
   );

endinterface

// File: rtl/frame_tick_gen.sv
// Free-running divider giving a one-cycle tick every FRAME_DIV clocks.
module frame_tick_gen #(
   parameter int FRAME_DIV = 833333
) (
   input  logic clock,
   input  logic reset,
   output logic tick
);

   localparam int W = $clog2(FRAME_DIV);

   logic [W-1:0] count;
   logic         wrap;

   assign wrap = (count == W'(FRAME_DIV - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
         tick  <= 1'b0;
      end else begin
         count <= wrap ? '0 : count + 1'b1;
         tick  <= wrap;
      end
   end

endmodule

// File: rtl/player_sprite_engine.sv
// Per-frame player sprite datapath: erase, move, probe for obstacles,
// redraw, then report collision / screen-end to the game FSM.
module player_sprite_engine
   import game_pkg::*;
#(
   parameter int SPRITE_W  = 4,
   parameter int SPRITE_H  = 4,
   parameter int X_START   = 78,
   parameter int STEP      = 1,
   parameter int FRAME_DIV = 833333
) (
   input  logic clock,
   input  logic reset,
   input  logic start,
   input  logic run,
   input  logic user_left,
   input  logic user_right,
   player_sprite_engine_if.master vga,
   output logic collided,
   output logic reached_screen_end,
   output logic busy
);

   localparam int X_MAX = SCREEN_W - SPRITE_W;
   localparam int Y_MAX = SCREEN_H - SPRITE_H;

   sprite_state_t state;

   logic [7:0] pos_x, dx, ndx, nx;
   logic [6:0] pos_y, dy, ndy, ny;
   logic       hit, cmp, wrap, last, tick;

   frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
      .clock (clock),
      .reset (reset),
      .tick  (tick)
   );

   // Shared row-major footprint walk plus next-position arithmetic.
   always_comb begin
      last = (dx == 8'(SPRITE_W - 1)) && (dy == 7'(SPRITE_H - 1));
      ndx  = dx + 8'd1;
      ndy  = dy;
      if (dx == 8'(SPRITE_W - 1)) begin
         ndx = '0;
         ndy = last ? '0 : dy + 7'd1;
      end
      ny = (int'(pos_y) >= Y_MAX) ? 7'(Y_MAX) : pos_y + 7'd1;
      nx = pos_x;
      if (user_left && !user_right)
         nx = (int'(pos_x) < STEP) ? '0 : pos_x - 8'(STEP);
      else if (user_right && !user_left)
         nx = (int'(pos_x) + STEP > X_MAX) ? 8'(X_MAX) : pos_x + 8'(STEP);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state              <= S_IDLE;
         pos_x              <= 8'(X_START);
         pos_y              <= '0;
         dx                 <= '0;
         dy                 <= '0;
         hit                <= 1'b0;
         cmp                <= 1'b0;
         wrap               <= 1'b0;
         collided           <= 1'b0;
         reached_screen_end <= 1'b0;
         busy               <= 1'b0;
         vga.plot           <= 1'b0;
         vga.x              <= '0;
         vga.y              <= '0;
         vga.colour         <= '0;
         vga.rd_x           <= '0;
         vga.rd_y           <= '0;
      end else if (start) begin
         state              <= S_IDLE;
         pos_x              <= 8'(X_START);
         pos_y              <= '0;
         dx                 <= '0;
         dy                 <= '0;
         hit                <= 1'b0;
         cmp                <= 1'b0;
         wrap               <= 1'b0;
         collided           <= 1'b0;
         reached_screen_end <= 1'b0;
         busy               <= 1'b0;
         vga.plot           <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (tick && run && !collided && !reached_screen_end) begin
                  state <= S_ERASE;
                  busy  <= 1'b1;
                  dx    <= '0;
                  dy    <= '0;
               end
            end
            S_ERASE: begin
               vga.plot   <= 1'b1;
               vga.x      <= pos_x + dx;
               vga.y      <= pos_y + dy;
               vga.colour <= BG_COLOUR;
               dx         <= ndx;
               dy         <= ndy;
               if (last) state <= S_UPDATE;
            end
            S_UPDATE: begin
               // First probe address is presented here so PROBE
               // sees data from its second cycle onwards.
               vga.plot <= 1'b0;
               pos_x    <= nx;
               pos_y    <= ny;
               vga.rd_x <= nx;
               vga.rd_y <= ny;
               dx       <= '0;
               dy       <= '0;
               cmp      <= 1'b0;
               wrap     <= 1'b0;
               state    <= S_PROBE;
            end
            S_PROBE: begin
               cmp <= 1'b1;
               if (cmp && vga.rd_colour == OBSTACLE_COLOUR) hit <= 1'b1;
               if (wrap) begin
                  wrap  <= 1'b0;
                  state <= S_DRAW;
               end else begin
                  dx       <= ndx;
                  dy       <= ndy;
                  vga.rd_x <= pos_x + ndx;
                  vga.rd_y <= pos_y + ndy;
                  wrap     <= last;
               end
            end
            S_DRAW: begin
               vga.plot   <= 1'b1;
               vga.x      <= pos_x + dx;
               vga.y      <= pos_y + dy;
               vga.colour <= PLAYER_COLOUR;
               dx         <= ndx;
               dy         <= ndy;
               if (last) state <= S_DONE;
            end
            S_DONE: begin
               vga.plot           <= 1'b0;
               collided           <= hit;
               reached_screen_end <= (pos_y == 7'(Y_MAX));
               busy               <= 1'b0;
               state              <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_player_sprite_engine.sv
// Directed bench for player_sprite_engine with a one-obstacle framebuffer.
module tb_player_sprite_engine;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic run = 1'b0;
   logic user_left = 1'b0;
   logic user_right = 1'b0;
   logic collided, reached_screen_end, busy;

   player_sprite_engine_if vga();

   player_sprite_engine #(
      .SPRITE_W(4), .SPRITE_H(4), .X_START(78), .STEP(1), .FRAME_DIV(64)
   ) dut (
      .clock(clock),
      .reset(reset),
      .start(start),
      .run(run),
      .user_left(user_left),
      .user_right(user_right),
      .vga(vga),
      .collided(collided),
      .reached_screen_end(reached_screen_end),
      .busy(busy)
   );

   always #10 clock = ~clock;

   logic       obs_en = 1'b0;
   logic [7:0] obs_x = 8'd0;
   logic [6:0] obs_y = 7'd0;

   always @(posedge clock)
      vga.rd_colour <= (obs_en && vga.rd_x == obs_x && vga.rd_y == obs_y)
                       ? 3'b010 : 3'b000;

   logic [17:0] plots[$];
   int busy_cnt;
   bit started;
   int n_pass = 0;
   int n_checks = 0;

   task automatic do_frame();
      plots.delete();
      busy_cnt = 0;
      started = 0;
      for (int i = 0; i < 100 && !started; i++) begin
         @(negedge clock);
         if (vga.plot) plots.push_back({vga.x, vga.y, vga.colour});
         if (busy) started = 1;
      end
      if (started) begin
         busy_cnt = 1;
         for (int i = 0; i < 100 && busy; i++) begin
            @(negedge clock);
            if (vga.plot) plots.push_back({vga.x, vga.y, vga.colour});
            if (busy) busy_cnt++;
         end
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic wait_draw(input int nth, output bit ok);
      int cnt = 0;
      for (int i = 0; i < 100 && !busy; i++) @(negedge clock);
      for (int i = 0; i < 80 && cnt < nth && busy; i++) begin
         @(negedge clock);
         if (vga.plot && vga.colour == 3'b110) cnt++;
      end
      ok = (cnt == nth);
   endtask

   task automatic test_reset();
      logic [43:0] got;
      got = {vga.plot, collided, reached_screen_end, busy, vga.x, vga.y,
             vga.colour, vga.rd_x, vga.rd_y, 3'b000};
      n_checks++;
      if (got !== 44'd0) $display("FAIL reset_outputs: got %h, want 0", got);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b, want 0", busy);
      else n_pass++;
   endtask

   task automatic test_first_frame();
      logic [17:0] e;
      do_frame();
      n_checks++;
      if (plots.size() != 32)
         $display("FAIL first_plot_count: got %0d, want 32", plots.size());
      else n_pass++;
      if (plots.size() == 32) begin
         for (int k = 0; k < 32; k++) begin
            e = {8'(78 + k % 4), 7'((k % 16) / 4 + k / 16),
                 (k < 16) ? 3'b000 : 3'b110};
            n_checks++;
            if (plots[k] !== e)
               $display("FAIL first_pixel[%0d]: got %h, want %h", k, plots[k], e);
            else n_pass++;
         end
      end
      n_checks++;
      if (busy_cnt != 51) $display("FAIL first_busy: got %0d, want 51", busy_cnt);
      else n_pass++;
      n_checks++;
      if (collided !== 1'b0) $display("FAIL first_collided: got %b, want 0", collided);
      else n_pass++;
   endtask

   task automatic test_left_clamp();
      pulse_start();
      user_left = 1'b1;
      for (int i = 0; i < 78; i++) do_frame();
      n_checks++;
      if (plots[16][17:10] !== 8'd0 || plots[16][9:3] !== 7'd78)
         $display("FAIL left_reach: got (%0d,%0d), want (0,78)",
                  plots[16][17:10], plots[16][9:3]);
      else n_pass++;
      do_frame();
      n_checks++;
      if (plots[0][17:10] !== 8'd0 || plots[0][9:3] !== 7'd78)
         $display("FAIL left_erase: got (%0d,%0d), want (0,78)",
                  plots[0][17:10], plots[0][9:3]);
      else n_pass++;
      n_checks++;
      if (plots[16][17:10] !== 8'd0 || plots[16][9:3] !== 7'd79)
         $display("FAIL left_clamp: got (%0d,%0d), want (0,79)",
                  plots[16][17:10], plots[16][9:3]);
      else n_pass++;
      user_left = 1'b0;
   endtask

   task automatic test_right_clamp();
      pulse_start();
      user_right = 1'b1;
      for (int i = 0; i < 78; i++) do_frame();
      n_checks++;
      if (plots[16][17:10] !== 8'd156 || plots[16][9:3] !== 7'd78)
         $display("FAIL right_reach: got (%0d,%0d), want (156,78)",
                  plots[16][17:10], plots[16][9:3]);
      else n_pass++;
      do_frame();
      n_checks++;
      if (plots[16][17:10] !== 8'd156 || plots[16][9:3] !== 7'd79)
         $display("FAIL right_clamp: got (%0d,%0d), want (156,79)",
                  plots[16][17:10], plots[16][9:3]);
      else n_pass++;
      n_checks++;
      if (plots[31][17:10] !== 8'd159)
         $display("FAIL right_edge: got %0d, want 159", plots[31][17:10]);
      else n_pass++;
      user_right = 1'b0;
   endtask

   task automatic test_steer_patterns();
      logic [7:0] ex[4] = '{8'd78, 8'd78, 8'd77, 8'd78};
      logic [1:0] lr[4] = '{2'b11, 2'b00, 2'b10, 2'b01};
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         {user_left, user_right} = lr[i];
         do_frame();
         n_checks++;
         if (plots[16][17:10] !== ex[i] || plots[16][9:3] !== 7'(i + 1))
            $display("FAIL steer[%0d]: got (%0d,%0d), want (%0d,%0d)", i,
                     plots[16][17:10], plots[16][9:3], ex[i], i + 1);
         else n_pass++;
      end
      {user_left, user_right} = 2'b00;
   endtask

   task automatic test_collision();
      pulse_start();
      obs_x = 8'd82; obs_y = 7'd1; obs_en = 1'b1;
      do_frame();
      n_checks++;
      if (collided !== 1'b0) $display("FAIL near_miss: got %b, want 0", collided);
      else n_pass++;
      obs_x = 8'd80; obs_y = 7'd5;
      do_frame();
      n_checks++;
      if (collided !== 1'b1) $display("FAIL collide_set: got %b, want 1", collided);
      else n_pass++;
      n_checks++;
      if (plots.size() != 32 || plots[31] !== {8'd81, 7'd5, 3'b110})
         $display("FAIL collide_draw: got %0d plots last %h, want 32 last %h",
                  plots.size(), plots[31], {8'd81, 7'd5, 3'b110});
      else n_pass++;
      do_frame();
      n_checks++;
      if (started || plots.size() != 0)
         $display("FAIL collide_frozen: got started=%b plots=%0d, want 0 0",
                  started, plots.size());
      else n_pass++;
      obs_en = 1'b0;
      pulse_start();
      n_checks++;
      if (collided !== 1'b0) $display("FAIL start_clears_collided: got %b, want 0", collided);
      else n_pass++;
   endtask

   task automatic test_screen_end();
      pulse_start();
      for (int i = 0; i < 115; i++) do_frame();
      n_checks++;
      if (reached_screen_end !== 1'b0)
         $display("FAIL end_early: got %b, want 0", reached_screen_end);
      else n_pass++;
      do_frame();
      n_checks++;
      if (reached_screen_end !== 1'b1)
         $display("FAIL end_set: got %b, want 1", reached_screen_end);
      else n_pass++;
      n_checks++;
      if (plots[16][9:3] !== 7'd116 || plots[31][9:3] !== 7'd119)
         $display("FAIL end_rows: got %0d..%0d, want 116..119",
                  plots[16][9:3], plots[31][9:3]);
      else n_pass++;
      do_frame();
      n_checks++;
      if (started || plots.size() != 0)
         $display("FAIL end_frozen: got started=%b plots=%0d, want 0 0",
                  started, plots.size());
      else n_pass++;
      pulse_start();
      n_checks++;
      if (reached_screen_end !== 1'b0)
         $display("FAIL start_clears_end: got %b, want 0", reached_screen_end);
      else n_pass++;
   endtask

   task automatic test_start_mid_draw();
      bit ok;
      wait_draw(8, ok);
      n_checks++;
      if (ok !== 1'b1) $display("FAIL mid_draw_reach: got %b, want 1", ok);
      else n_pass++;
      pulse_start();
      n_checks++;
      if ({vga.plot, busy} !== 2'b00)
         $display("FAIL mid_draw_stop: got plot=%b busy=%b, want 0 0", vga.plot, busy);
      else n_pass++;
      n_checks++;
      if ({vga.x, vga.y, vga.colour} !== {8'd81, 7'd2, 3'b110})
         $display("FAIL mid_draw_hold: got %h, want %h",
                  {vga.x, vga.y, vga.colour}, {8'd81, 7'd2, 3'b110});
      else n_pass++;
      do_frame();
      n_checks++;
      if (plots[0] !== {8'd78, 7'd0, 3'b000} || plots[16] !== {8'd78, 7'd1, 3'b110})
         $display("FAIL mid_draw_restart: got %h %h, want %h %h", plots[0], plots[16],
                  {8'd78, 7'd0, 3'b000}, {8'd78, 7'd1, 3'b110});
      else n_pass++;
   endtask

   task automatic test_reset_and_start();
      bit ok;
      logic [39:0] got;
      wait_draw(8, ok);
      n_checks++;
      if (ok !== 1'b1) $display("FAIL rst_draw_reach: got %b, want 1", ok);
      else n_pass++;
      reset = 1'b1;
      start = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      start = 1'b0;
      got = {vga.plot, collided, reached_screen_end, busy, vga.x, vga.y,
             vga.colour, vga.rd_x, vga.rd_y, 3'b000};
      n_checks++;
      if (got !== 40'd0) $display("FAIL rst_start_values: got %h, want 0", got);
      else n_pass++;
      do_frame();
      n_checks++;
      if (plots[0] !== {8'd78, 7'd0, 3'b000} || busy_cnt != 51)
         $display("FAIL rst_restart: got %h busy=%0d, want %h busy=51",
                  plots[0], busy_cnt, {8'd78, 7'd0, 3'b000});
      else n_pass++;
   endtask

   initial begin
      repeat (3) @(negedge clock);
      reset = 1'b0;
      test_reset();
      run = 1'b1;
      pulse_start();
      test_first_frame();
      test_left_clamp();
      test_right_clamp();
      test_steer_patterns();
      test_collision();
      test_screen_end();
      test_start_mid_draw();
      test_reset_and_start();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/player_sprite_engine.md
# player_sprite_engine

Per-frame player datapath for the falling-sprite game: on each frame tick it erases the player sprite, advances its position (gravity plus left/right steering), probes the framebuffer under the new position for obstacle pixels and redraws the sprite. It drives the 160x120, 3-bit-colour VGA adapter plot port. It is the producer of `collided` and `reached_screen_end`, which the game-control FSM consumes.

## Interface
- `SPRITE_W`, default 4: sprite width in pixels.
- `SPRITE_H`, default 4: sprite height in pixels.
- `X_START`, default 78: initial x of the sprite's top-left pixel.
- `STEP`, default 1: x pixels moved per frame while steering.
- `FRAME_DIV`, default 833333: clock cycles per frame tick; must be at least 64.
- `clock` in 1: system clock, 50 MHz.
- `reset` in 1: reset, synchronous, active-high; clock `clock`.
- `start` in 1: one-cycle pulse from the game FSM that re-arms the round.
- `run` in 1: high while the game FSM is in its playing state.
- `user_left` in 1: steer left, sampled at UPDATE.
- `user_right` in 1: steer right, sampled at UPDATE.
- `rd_x` out 8: framebuffer read x address.
- `rd_y` out 7: framebuffer read y address.
- `rd_colour` in 3: framebuffer read data, valid 1 cycle after the address.
- `x` out 8: VGA plot x.
- `y` out 7: VGA plot y.
- `colour` out 3: VGA plot colour.
- `plot` out 1: VGA write strobe.
- `collided` out 1: sticky; obstacle pixel found under the sprite.
- `reached_screen_end` out 1: sticky; sprite bottom row is on y=119.
- `busy` out 1: high in any state other than IDLE.

## Operation
- State machine: IDLE -> ERASE -> UPDATE -> PROBE -> DRAW -> DONE -> IDLE.
- IDLE:
  - Leaves on a frame tick only when `run`=1, `collided`=0 and `reached_screen_end`=0.
  - Otherwise the tick is dropped.
- ERASE:
  - Plots SPRITE_W*SPRITE_H pixels of BG_COLOUR (3'b000) at the old position.
  - Scan is row-major: dx is the inner loop, dy the outer loop.
- UPDATE (1 cycle):
  - `pos_y` <= min(pos_y+1, 120-SPRITE_H).
  - If exactly one of `user_left` or `user_right` is high, `pos_x` moves by STEP in that direction, clamped to [0, 160-SPRITE_W].
  - If both or neither are high, `pos_x` does not change.
- PROBE:
  - Issues the row-major read addresses of the new footprint, one per cycle.
  - Compares each returned `rd_colour` with OBSTACLE_COLOUR (3'b010).
  - Any match sets the internal hit flag.
  - The sprite's own pixels are already erased, so the sprite never hits itself.
- DRAW:
  - Plots the footprint in PLAYER_COLOUR (3'b110) at the new position.
  - Draws even when hit is set, so the crash stays visible.
- DONE:
  - `collided` <= hit.
  - `reached_screen_end` <= (pos_y == 120-SPRITE_H).
  - Both flags assert in the same cycle if both conditions hold.
- `start`:
  - From any state: returns to IDLE, sets pos=(X_START,0), clears both flags and hit, and deasserts `plot`.
  - No erase is performed; the game FSM clears the screen.
- Outputs are registered.
- `x`/`y`/`colour` hold their last value while `plot`=0.
- `rd_x`/`rd_y` are don't-care outside PROBE.

## Timing
- Reset values:
  - state=IDLE, pos=(X_START,0).
  - `plot`=0, `collided`=0, `reached_screen_end`=0, `busy`=0.
  - `x`=0, `y`=0, `colour`=0, `rd_x`=0, `rd_y`=0.
  - Tick divider=0.
- Cycle counts with N=SPRITE_W*SPRITE_H (16 by default):
  - ERASE: N cycles.
  - UPDATE: 1 cycle.
  - PROBE: N+1 cycles; the last compare takes place in the cycle after the last address.
  - DRAW: N cycles.
  - DONE: 1 cycle.
  - Total: 3N+3 = 51 cycles from tick to IDLE.
- Flags are visible in the cycle after DONE.
- `plot` is high for exactly N consecutive cycles in ERASE and N in DRAW.
- Frame tick:
  - A single-cycle pulse every FRAME_DIV cycles.
  - The divider runs freely and is not reset by `start`.
- Precedence:
  - `reset` has priority over `start`.
  - `start` has priority over a tick in the same cycle; that tick is dropped.
- `run` falling mid-sequence does not abort the sequence; it completes to IDLE.
- Reset mid-sequence: the next cycle has `plot`=0 and state IDLE; the half-drawn sprite is left on screen.

## Structure
- Package `game_pkg` holds:
  - SCREEN_W=160, SCREEN_H=120.
  - BG_COLOUR, OBSTACLE_COLOUR, PLAYER_COLOUR.
  - The sprite-engine state enum.
- The shared colour constants replace the literal 3'b010 test currently hard-coded in the collision logic.
- Sub-module `frame_tick_gen` (parameter FRAME_DIV; ports `clock`, `reset`, `tick`) is instantiated once.
- A shared row-major footprint counter (dx, dy) is reused by ERASE, PROBE and DRAW.

## Test plan
- Reset, then `start`, then `run`=1 with FRAME_DIV=64 and an empty framebuffer:
  - First tick gives 16 BG plots at (78..81, 0..3).
  - Then 16 PLAYER_COLOUR plots at (78..81, 1..4).
  - `collided`=0; `busy` is high for 51 cycles.
- `user_left`=1 with `pos_x`=0: `pos_x` stays 0 and `pos_y` still increments.
- `user_right`=1 with `pos_x`=156: `pos_x` stays 156.
- Both steering inputs high: `pos_x` is unchanged.
- Framebuffer model returns 3'b010 only at (80,5), sprite at (78,1):
  - The next tick sets `collided`=1 in the cycle after DONE; DRAW still occurs.
  - Later ticks produce no plots.
- Run from `pos_y`=0:
  - After 116 ticks, `pos_y`=116 and `reached_screen_end`=1.
  - Tick 117 produces no plot activity.
- `start` asserted mid-DRAW (8th plot):
  - `plot`=0 the next cycle, state IDLE, pos=(78,0), flags cleared.
  - Same scenario with `reset` and `start` asserted together: reset values result.
